// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer arbiter bus: pixel writer, scan-out reader, clear control,
// status flags and the single-port RAM connection, bundled in one interface.
// Signal names keep their arbiter-side direction suffixes so each one maps
// directly onto the block it belongs to.
interface fb_write_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 7
);
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_stall_o;
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_valid_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  clear_i;
    logic                  busy_o;
    logic                  overflow_o;
    logic [7:0]            drop_cnt_o;
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Arbiter side
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, clear_i, mem_rdata_i,
        output wr_stall_o, rd_valid_o, rd_data_o, busy_o, overflow_o, drop_cnt_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Producer / reader / RAM side
    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, clear_i, mem_rdata_i,
        input  wr_stall_o, rd_valid_o, rd_data_o, busy_o, overflow_o, drop_cnt_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: shares a single-port RAM between buffered pixel
// writes and fixed-latency scan-out reads, with a clear engine that zeroes
// the whole buffer after reset or on request.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 7,
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WORDS   = 38400
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fb_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WORDS - 1);
    localparam logic [PTR_W:0]        OCC_HI    = (PTR_W + 1)'(FIFO_DEPTH - 2);

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } stateT;

    stateT                 stateQ;
    logic [ADDR_WIDTH-1:0] caQ;
    logic                  memEnQ;
    logic                  memWeQ;
    logic [ADDR_WIDTH-1:0] memAddrQ;
    logic [DATA_WIDTH-1:0] memWdataQ;
    logic                  wrStallQ;

    logic [ADDR_WIDTH-1:0] fifoAddr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifoData [FIFO_DEPTH];
    logic [PTR_W:0]        wrPtrQ, wrPtrD;
    logic [PTR_W:0]        rdPtrQ, rdPtrD;
    logic [PTR_W:0]        occupancy;
    logic                  fifoEmpty, fifoFull;

    logic                  doRead, doClear, doPop;
    logic                  inRange, pushOk, dropRange, dropFull;

    logic                  overflowQ, overflowD;
    logic [7:0]            dropCntQ, dropCntD;

    logic [1:0]            rdPipeQ;
    logic                  rdStageValidQ;
    logic [DATA_WIDTH-1:0] rdStageDataQ;
    logic                  rdValidQ;
    logic [DATA_WIDTH-1:0] rdDataQ;

    // Slot decision, FIFO status and next pointer / drop-counter values
    always_comb begin
        occupancy = wrPtrQ - rdPtrQ;
        fifoEmpty = (wrPtrQ == rdPtrQ);
        fifoFull  = (wrPtrQ[PTR_W] != rdPtrQ[PTR_W]) &&
                    (wrPtrQ[PTR_W-1:0] == rdPtrQ[PTR_W-1:0]);

        doRead  = bus.rd_req_i;
        doClear = !doRead && (stateQ == StClear);
        doPop   = !doRead && (stateQ == StRun) && !fifoEmpty;

        inRange   = (bus.wr_addr_i <= LAST_ADDR);
        pushOk    = bus.wr_en_i && inRange && (!fifoFull || doPop);
        dropRange = bus.wr_en_i && !inRange;
        dropFull  = bus.wr_en_i && inRange && fifoFull && !doPop;

        wrPtrD = pushOk ? (wrPtrQ + 1'b1) : wrPtrQ;
        rdPtrD = doPop  ? (rdPtrQ + 1'b1) : rdPtrQ;

        overflowD = overflowQ;
        dropCntD  = dropCntQ;
        if (bus.clear_i) begin
            overflowD = 1'b0;
            dropCntD  = 8'd0;
        end else begin
            if (dropFull) begin
                overflowD = 1'b1;
            end
            if ((dropFull || dropRange) && (dropCntQ != 8'hFF)) begin
                dropCntD = dropCntQ + 8'd1;
            end
        end
    end

    // FIFO storage; the head entry is read combinationally on pop
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            fifoAddr[wrPtrQ[PTR_W-1:0]] <= bus.wr_addr_i;
            fifoData[wrPtrQ[PTR_W-1:0]] <= bus.wr_data_i;
        end
    end

    // FIFO pointers and sticky drop status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            overflowQ <= 1'b0;
            dropCntQ  <= 8'd0;
        end else begin
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            overflowQ <= overflowD;
            dropCntQ  <= dropCntD;
        end
    end

    // Clear/run FSM driving the registered RAM port and the producer stall
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ    <= StClear;
            caQ       <= '0;
            memEnQ    <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            wrStallQ  <= 1'b0;
        end else begin
            memEnQ   <= 1'b0;
            memWeQ   <= 1'b0;
            wrStallQ <= (occupancy >= OCC_HI) || (stateQ == StClear);
            if (doRead) begin
                memEnQ   <= 1'b1;
                memAddrQ <= bus.rd_addr_i;
            end else if (doClear) begin
                memEnQ    <= 1'b1;
                memWeQ    <= 1'b1;
                memAddrQ  <= caQ;
                memWdataQ <= '0;
                if (caQ == LAST_ADDR) begin
                    stateQ <= StRun;
                    caQ    <= '0;
                end else begin
                    caQ <= caQ + 1'b1;
                end
            end else if (doPop) begin
                memEnQ    <= 1'b1;
                memWeQ    <= 1'b1;
                memAddrQ  <= fifoAddr[rdPtrQ[PTR_W-1:0]];
                memWdataQ <= fifoData[rdPtrQ[PTR_W-1:0]];
            end
            if (bus.clear_i) begin
                stateQ <= StClear;
                caQ    <= '0;
            end
        end
    end

    // Read return pipeline: two slots of RAM latency, a capture stage, then the output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPipeQ       <= '0;
            rdStageValidQ <= 1'b0;
            rdStageDataQ  <= '0;
            rdValidQ      <= 1'b0;
            rdDataQ       <= '0;
        end else begin
            rdPipeQ       <= {rdPipeQ[0], doRead};
            rdStageValidQ <= rdPipeQ[1];
            rdStageDataQ  <= bus.mem_rdata_i;
            rdValidQ      <= rdStageValidQ;
            if (rdStageValidQ) begin
                rdDataQ <= rdStageDataQ;
            end
        end
    end

    assign bus.mem_en_o    = memEnQ;
    assign bus.mem_we_o    = memWeQ;
    assign bus.mem_addr_o  = memAddrQ;
    assign bus.mem_wdata_o = memWdataQ;
    assign bus.wr_stall_o  = wrStallQ;
    assign bus.busy_o      = (stateQ == StClear);
    assign bus.overflow_o  = overflowQ;
    assign bus.drop_cnt_o  = dropCntQ;
    assign bus.rd_valid_o  = rdValidQ;
    assign bus.rd_data_o   = rdDataQ;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed testbench for fb_write_arbiter with a behavioural single-port RAM.
module tb_fb_write_arbiter;
    logic clk_i;
    logic rst_ni;
    int   checkCount;
    int   errorCount;

    fb_write_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(7)) bus ();

    fb_write_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(7),
        .FIFO_DEPTH(8),
        .FB_WORDS(38400)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single-port RAM model: read data appears one cycle after a read enable
    logic [6:0] ram [0:65535];
    logic [6:0] ramRdata;
    always @(posedge clk_i) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              ramRdata <= ram[bus.mem_addr_o];
        end
    end
    assign bus.mem_rdata_i = ramRdata;

    // Global time limit so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, step past the next rising edge
    task automatic applyStimulus(input logic rdReq, input logic [15:0] rdAddr,
                                 input logic wrEn, input logic [15:0] wrAddr,
                                 input logic [6:0] wrData, input logic clr);
        bus.rd_req_i  = rdReq;
        bus.rd_addr_i = rdAddr;
        bus.wr_en_i   = wrEn;
        bus.wr_addr_i = wrAddr;
        bus.wr_data_i = wrData;
        bus.clear_i   = clr;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] memOp();
        return {7'd0, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
    endfunction

    function automatic logic [31:0] memCmd();
        return {14'd0, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o};
    endfunction

    function automatic logic [31:0] expWrite(input logic [15:0] a, input logic [6:0] d);
        return {7'd0, 1'b1, 1'b1, a, d};
    endfunction

    function automatic logic [31:0] expRead(input logic [15:0] a);
        return {14'd0, 1'b1, 1'b0, a};
    endfunction

    function automatic logic [15:0] t3Addr(input int j);
        return (j % 2 == 1) ? 16'd100 : 16'(200 + j);
    endfunction

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        rst_ni        = 1'b0;
        bus.rd_req_i  = 1'b0;
        bus.rd_addr_i = '0;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.clear_i   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rstMemOp",   memOp(), 32'd0);
        checkOutput("rstBusy",    32'(bus.busy_o), 32'd1);
        checkOutput("rstStall",   32'(bus.wr_stall_o), 32'd0);
        checkOutput("rstValid",   32'(bus.rd_valid_o), 32'd0);
        checkOutput("rstOvf",     32'(bus.overflow_o), 32'd0);
        checkOutput("rstDrop",    32'(bus.drop_cnt_o), 32'd0);
        rst_ni = 1'b1;

        // T1: full clear after reset release
        $display("[TB] T1 clear after reset");
        for (int i = 0; i < 38400; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
            checkOutput("t1ClearOp", memOp(), expWrite(16'(i), 7'd0));
            if (i == 0) begin
                checkOutput("t1BusyStart",  32'(bus.busy_o), 32'd1);
                checkOutput("t1StallStart", 32'(bus.wr_stall_o), 32'd1);
            end
            if (i == 38399) begin
                checkOutput("t1BusyEnd",  32'(bus.busy_o), 32'd0);
                checkOutput("t1StallEnd", 32'(bus.wr_stall_o), 32'd1);
            end
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t1IdleEn",  32'(bus.mem_en_o), 32'd0);
        checkOutput("t1StallLo", 32'(bus.wr_stall_o), 32'd0);

        // T2: single write then read-back
        $display("[TB] T2 write and read back");
        applyStimulus(1'b0, 16'd0, 1'b1, 16'd100, 7'h2A, 1'b0);
        checkOutput("t2PushEn", 32'(bus.mem_en_o), 32'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t2WriteOp", memOp(), expWrite(16'd100, 7'h2A));
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        applyStimulus(1'b1, 16'd100, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t2ReadCmd", memCmd(), expRead(16'd100));
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t2ValidEarly", 32'(bus.rd_valid_o), 32'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t2Valid", 32'(bus.rd_valid_o), 32'd1);
        checkOutput("t2Data",  32'(bus.rd_data_o), 32'h2A);
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t2ValidOff", 32'(bus.rd_valid_o), 32'd0);
        checkOutput("t2DataHold", 32'(bus.rd_data_o), 32'h2A);

        // T3: 20 back-to-back reads while 6 writes queue up
        $display("[TB] T3 read burst with queued writes");
        for (int j = 0; j < 30; j++) begin
            applyStimulus(j < 20, t3Addr(j), j < 6, 16'(300 + j), 7'(10 + j), 1'b0);
            checkOutput("t3Valid", 32'(bus.rd_valid_o), 32'((j >= 3) && (j < 23)));
            if ((j >= 3) && (j < 23)) begin
                checkOutput("t3Data", 32'(bus.rd_data_o),
                            (((j - 3) % 2) == 1) ? 32'h2A : 32'h0);
            end
            if (j < 20)      checkOutput("t3ReadCmd", memCmd(), expRead(t3Addr(j)));
            else if (j < 26) checkOutput("t3WriteOp", memOp(), expWrite(16'(300 + j - 20), 7'(10 + j - 20)));
            else             checkOutput("t3IdleEn", 32'(bus.mem_en_o), 32'd0);
        end
        checkOutput("t3Drop", 32'(bus.drop_cnt_o), 32'd0);

        // T5: out-of-range addresses are dropped without overflow
        $display("[TB] T5 out-of-range writes");
        applyStimulus(1'b0, 16'd0, 1'b1, 16'd38400, 7'h01, 1'b0);
        checkOutput("t5En0", 32'(bus.mem_en_o), 32'd0);
        applyStimulus(1'b0, 16'd0, 1'b1, 16'd65535, 7'h02, 1'b0);
        checkOutput("t5En1", 32'(bus.mem_en_o), 32'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t5En2", 32'(bus.mem_en_o), 32'd0);
        checkOutput("t5Drop", 32'(bus.drop_cnt_o), 32'd2);
        checkOutput("t5Ovf",  32'(bus.overflow_o), 32'd0);

        // T4: FIFO fills under continuous reads, last two writes overflow
        $display("[TB] T4 FIFO overflow");
        for (int j = 0; j < 22; j++) begin
            applyStimulus(j < 12, 16'(500 + j), j < 10, 16'(400 + j), 7'(40 + j), 1'b0);
            if (j == 5)  checkOutput("t4StallPre", 32'(bus.wr_stall_o), 32'd0);
            if (j == 6)  checkOutput("t4Stall",    32'(bus.wr_stall_o), 32'd1);
            if (j == 7)  checkOutput("t4OvfPre",   32'(bus.overflow_o), 32'd0);
            if (j == 8)  checkOutput("t4Ovf",      32'(bus.overflow_o), 32'd1);
            if (j == 8)  checkOutput("t4Drop3",    32'(bus.drop_cnt_o), 32'd3);
            if (j == 9)  checkOutput("t4Drop4",    32'(bus.drop_cnt_o), 32'd4);
            if (j < 12)      checkOutput("t4ReadCmd", memCmd(), expRead(16'(500 + j)));
            else if (j < 20) checkOutput("t4WriteOp", memOp(), expWrite(16'(400 + j - 12), 7'(40 + j - 12)));
            else             checkOutput("t4IdleEn", 32'(bus.mem_en_o), 32'd0);
            if (j == 19) checkOutput("t4StallLo", 32'(bus.wr_stall_o), 32'd0);
        end
        checkOutput("t4OvfHold",  32'(bus.overflow_o), 32'd1);
        checkOutput("t4DropHold", 32'(bus.drop_cnt_o), 32'd4);

        // Drop counter saturation
        $display("[TB] drop counter saturation");
        repeat (255) applyStimulus(1'b0, 16'd0, 1'b1, 16'd65535, 7'd0, 1'b0);
        checkOutput("satDrop", 32'(bus.drop_cnt_o), 32'd255);
        applyStimulus(1'b0, 16'd0, 1'b1, 16'd40000, 7'd0, 1'b0);
        checkOutput("satDropHold", 32'(bus.drop_cnt_o), 32'd255);

        // T6: clear request, restart mid-clear, then async reset mid-clear
        $display("[TB] T6 clear restart and async reset");
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b1);
        checkOutput("t6ClrEn",   32'(bus.mem_en_o), 32'd0);
        checkOutput("t6ClrBusy", 32'(bus.busy_o), 32'd1);
        checkOutput("t6ClrDrop", 32'(bus.drop_cnt_o), 32'd0);
        checkOutput("t6ClrOvf",  32'(bus.overflow_o), 32'd0);
        for (int k = 0; k <= 500; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
            checkOutput("t6ClearOp", memOp(), expWrite(16'(k), 7'd0));
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b1);
        checkOutput("t6LastOp", memOp(), expWrite(16'd501, 7'd0));
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t6Restart0", memOp(), expWrite(16'd0, 7'd0));
        for (int k = 1; k < 100; k++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        end
        checkOutput("t6MidOp",    memOp(), expWrite(16'd99, 7'd0));
        checkOutput("t6MidStall", 32'(bus.wr_stall_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("t6AsyncOp",    memOp(), 32'd0);
        checkOutput("t6AsyncStall", 32'(bus.wr_stall_o), 32'd0);
        checkOutput("t6AsyncBusy",  32'(bus.busy_o), 32'd1);
        @(posedge clk_i);
        #1;
        checkOutput("t6HeldOp", memOp(), 32'd0);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t6RstOp0", memOp(), expWrite(16'd0, 7'd0));
        applyStimulus(1'b0, 16'd0, 1'b0, 16'd0, 7'd0, 1'b0);
        checkOutput("t6RstOp1", memOp(), expWrite(16'd1, 7'd0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
